// File: rtl/qbus_pkg.sv
// qbus_pkg: shared FSM states, address-width constants and byte-lane select encoding for the Q-bus bridge
package qbus_pkg;
    typedef enum logic [2:0] {IDLE, RD, WSET, WR, IAK, DRV, HOLD} state_t;
    localparam int AW_STD = 16;
    localparam int AW_EXT = 22;
    localparam logic [1:0] SEL_WORD = 2'b11;
    function automatic logic [1:0] sel_enc(input logic byte_en, input logic a0);
        return byte_en ? {a0, ~a0} : SEL_WORD;
    endfunction
endpackage

// File: rtl/qbus_wb_bridge_if.sv
// qbus_wb_bridge_if: Wishbone data master and interrupt-vector fetch port of the Q-bus bridge
interface qbus_wb_bridge_if
    import qbus_pkg::*;
#(
    parameter int AW = AW_STD
);
    logic [AW-1:0] wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i;
    logic wbm_cyc_o;
    logic wbm_stb_o;
    logic wbm_we_o;
    logic [1:0] wbm_sel_o;
    logic wbm_ack_i;
    logic [15:0] wbi_dat_i;
    logic wbi_stb_o;
    logic wbi_ack_i;
    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbi_stb_o,
        input wbm_dat_i, wbm_ack_i, wbi_dat_i, wbi_ack_i
    );
    modport slave (
        input wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbi_stb_o,
        output wbm_dat_i, wbm_ack_i, wbi_dat_i, wbi_ack_i
    );
endinterface

// File: rtl/qbus_clkgen.sv
// qbus_clkgen: divides vm_clk_p into the processor clock and flags the cycle it goes high
module qbus_clkgen #(
    parameter int DIV = 8
) (
    input logic vm_clk_p,
    input logic vm_rst_n,
    output logic qb_clk_o,
    output logic rise
);
    localparam int CW = $clog2(2 * DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic rise_n;
    logic fall_n;
    assign cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
    assign rise_n = cnt_n == HALF;
    assign fall_n = cnt_n == '0;
    assign rise = cnt == HALF;
    // clock output is registered from the next-count strobes so it tracks cnt without glitches
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            cnt <= '0;
            qb_clk_o <= 1'b0;
        end else begin
            cnt <= cnt_n;
            qb_clk_o <= rise_n ? 1'b1 : fall_n ? 1'b0 : qb_clk_o;
        end
    end
endmodule

// File: rtl/qbus_wb_bridge.sv
// qbus_wb_bridge: Q-bus slave that turns DATI/DATO/IAK bus cycles into Wishbone transfers
module qbus_wb_bridge
    import qbus_pkg::*;
#(
    parameter int AW = AW_STD,
    parameter int DIV = 8,
    parameter int SYNC_N = 2,
    parameter int WDLY = 2,
    parameter int TMO = 255,
    parameter int NIRQ = 4
) (
    input logic vm_clk_p,
    input logic vm_rst_n,
    input logic [AW-1:0] qb_ad_i,
    output logic [AW-1:0] qb_ad_o,
    output logic qb_ad_oe,
    input logic [4:0] qb_ctl_i,
    output logic qb_clk_o,
    output logic qb_rply_o,
    input logic [NIRQ-1:0] irq_i,
    output logic [NIRQ-1:0] qb_irq_o,
    output logic err_o,
    qbus_wb_bridge_if.master wb
);
    localparam logic [7:0] WDLY_L = 8'(WDLY);
    localparam logic [15:0] TMO_L = 16'(TMO);
    logic rise;
    logic [SYNC_N-1:0][4:0] ctl_q;
    logic iako, wtbt, dout, din, sync, sync_d;
    logic [AW-1:0] adr;
    state_t state, state_n;
    logic oe, oe_n, rply, rply_n, nrply, nrply_n, iak, iak_n, err, err_n;
    logic [1:0] sel, sel_n;
    logic [15:0] wdat, wdat_n, rdat, rdat_n;
    logic [7:0] dcnt, dcnt_n;
    logic [15:0] tcnt, tcnt_n;
    qbus_clkgen #(.DIV(DIV)) u_clkgen (
        .vm_clk_p(vm_clk_p),
        .vm_rst_n(vm_rst_n),
        .qb_clk_o(qb_clk_o),
        .rise(rise)
    );
    assign {iako, wtbt, dout, din, sync} = ctl_q[SYNC_N-1];
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            ctl_q <= '0;
            sync_d <= 1'b0;
            adr <= '0;
            qb_rply_o <= 1'b0;
            qb_irq_o <= '0;
        end else begin
            ctl_q <= {ctl_q[SYNC_N-2:0], qb_ctl_i};
            sync_d <= sync;
            if (sync && !sync_d)
                adr <= qb_ad_i;
            if (rise) begin
                qb_rply_o <= rply;
                qb_irq_o <= irq_i;
            end
        end
    end
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            state <= IDLE;
            oe <= 1'b0;
            rply <= 1'b0;
            nrply <= 1'b0;
            iak <= 1'b0;
            err <= 1'b0;
            sel <= '0;
            wdat <= '0;
            rdat <= '0;
            dcnt <= '0;
            tcnt <= '0;
        end else begin
            state <= state_n;
            oe <= oe_n;
            rply <= rply_n;
            nrply <= nrply_n;
            iak <= iak_n;
            err <= err_n;
            sel <= sel_n;
            wdat <= wdat_n;
            rdat <= rdat_n;
            dcnt <= dcnt_n;
            tcnt <= tcnt_n;
        end
    end
    // interrupt acknowledge runs with SYNC negated, so only non-IAK cycles abort on SYNC loss
    always_comb begin
        state_n = state;
        oe_n = oe;
        rply_n = rply;
        nrply_n = nrply;
        iak_n = iak;
        err_n = 1'b0;
        sel_n = sel;
        wdat_n = wdat;
        rdat_n = rdat;
        dcnt_n = '0;
        tcnt_n = '0;
        if (state != IDLE && !sync && !iak) begin
            state_n = IDLE;
            oe_n = 1'b0;
            rply_n = 1'b0;
            nrply_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync && din) begin
                        state_n = RD;
                        sel_n = SEL_WORD;
                    end else if (sync && dout) begin
                        state_n = WSET;
                    end else if (iako && din && !sync) begin
                        state_n = IAK;
                        iak_n = 1'b1;
                    end
                end
                RD, WR, IAK: begin
                    tcnt_n = tcnt + 16'd1;
                    if ((state == IAK) ? wb.wbi_ack_i : wb.wbm_ack_i) begin
                        rdat_n = (state == IAK) ? wb.wbi_dat_i : (state == RD) ? wb.wbm_dat_i : rdat;
                        state_n = (state == WR) ? HOLD : DRV;
                        oe_n = state != WR;
                        rply_n = state == WR;
                    end else if (TMO != 0 && tcnt + 16'd1 == TMO_L) begin
                        state_n = HOLD;
                        nrply_n = 1'b1;
                        err_n = 1'b1;
                    end
                end
                WSET: begin
                    dcnt_n = dcnt + 8'd1;
                    if (dcnt + 8'd1 >= WDLY_L) begin
                        wdat_n = qb_ad_i[15:0];
                        sel_n = sel_enc(wtbt, adr[0]);
                        state_n = WR;
                    end
                end
                DRV: begin
                    rply_n = 1'b1;
                    state_n = HOLD;
                end
                HOLD: begin
                    // after a timeout the processor traps on missing RPLY and ends the cycle by dropping SYNC
                    if (nrply ? !sync : (!din && !dout)) begin
                        state_n = IDLE;
                        oe_n = 1'b0;
                        rply_n = 1'b0;
                        nrply_n = 1'b0;
                        iak_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign wb.wbm_cyc_o = state == RD || state == WR;
    assign wb.wbm_stb_o = state == RD || state == WR;
    assign wb.wbm_we_o = state == WR;
    assign wb.wbm_sel_o = sel;
    assign wb.wbm_adr_o = adr;
    assign wb.wbm_dat_o = wdat;
    assign wb.wbi_stb_o = state == IAK;
    assign qb_ad_o = AW'(rdat);
    assign qb_ad_oe = oe;
    assign err_o = err;
endmodule
